// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller:
// coin codes, one-hot state encodings and coin-code decoding.
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_1    = 2'd1;
   localparam logic [1:0] COIN_2    = 2'd2;
   localparam logic [1:0] COIN_4    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_COLLECT = 3'b010,
      ST_LOCKOUT = 3'b100
   } state_e;

   // Coin code to value in 0.5-yuan units.
   function automatic logic [2:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  return 3'd1;
         COIN_2:  return 3'd2;
         COIN_4:  return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_stock_cnt.sv
// Product stock down-counter with refill load, decrement enable and a
// registered zero flag that tracks the counter on the same edge.
module vend_stock_cnt
   import vend_pkg::*;
#(
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               dec_i,
   output logic [STOCK_W-1:0] stock_o,
   output logic               zero_o
);

   localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] ONE_V  = {{(STOCK_W-1){1'b0}}, 1'b1};

   logic [STOCK_W-1:0] cnt_q, cnt_d;
   logic               zero_q, zero_d;

   // Next stock: a vend in a refill cycle takes one unit from the fresh load.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = dec_i ? (INIT_V - ONE_V) : INIT_V;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE_V;
      end else begin
         cnt_d = cnt_q;
      end
      zero_d = (cnt_d == '0);
   end

   // Stock and zero-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= INIT_V;
         zero_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign stock_o = cnt_q;
   assign zero_o  = zero_q;

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised coin-operated vending controller: credit accumulation,
// vend with change, cancel/refund and sold-out lockout with refill.
module vend_ctrl_param
   import vend_pkg::*;
#(
   parameter int PRICE      = 3,
   parameter int CREDIT_W   = 4,
   parameter int STOCK_INIT = 8,
   parameter int STOCK_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                refill,
   output logic                out_vld,
   output logic                change_vld,
   output logic [CREDIT_W-1:0] change,
   output logic [CREDIT_W-1:0] credit,
   output logic                sold_out
);

   localparam logic [CREDIT_W:0]   PRICE_V = (CREDIT_W+1)'(PRICE);
   localparam logic [STOCK_W-1:0]  ONE_S   = {{(STOCK_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                out_vld_q, out_vld_d;
   logic                change_vld_q, change_vld_d;

   logic [CREDIT_W:0]   coin_v_s;
   logic [CREDIT_W:0]   sum_s;
   logic [CREDIT_W-1:0] excess_s;
   logic                vend_s;
   logic                vend_empties_s;
   logic                stock_zero_s;
   logic [STOCK_W-1:0]  stock_s;

   assign coin_v_s = {{(CREDIT_W-2){1'b0}}, coin_value(coin)};
   assign sum_s    = {1'b0, credit_q} + coin_v_s;
   // Only consumed when sum >= PRICE, where the difference fits CREDIT_W bits.
   assign excess_s = sum_s[CREDIT_W-1:0] - PRICE_V[CREDIT_W-1:0];
   assign vend_empties_s = refill ? (STOCK_INIT == 1) : (stock_s == ONE_S);

   // Next-state, credit and output-pulse decisions in event priority order.
   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      change_d     = '0;
      change_vld_d = 1'b0;
      out_vld_d    = 1'b0;
      vend_s       = 1'b0;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (cancel) begin
               credit_d = '0;
               state_d  = ST_IDLE;
               if (sum_s != '0) begin
                  change_vld_d = 1'b1;
                  change_d     = sum_s[CREDIT_W-1:0];
               end else begin
                  change_vld_d = 1'b0;
               end
            end else if (sum_s >= PRICE_V) begin
               credit_d = '0;
               if (!stock_zero_s) begin
                  vend_s       = 1'b1;
                  out_vld_d    = 1'b1;
                  change_d     = excess_s;
                  change_vld_d = (sum_s > PRICE_V);
                  state_d      = vend_empties_s ? ST_LOCKOUT : ST_IDLE;
               end else begin
                  // Stock empty outside LOCKOUT only after state recovery: refund.
                  change_vld_d = 1'b1;
                  change_d     = sum_s[CREDIT_W-1:0];
                  state_d      = refill ? ST_IDLE : ST_LOCKOUT;
               end
            end else begin
               credit_d = sum_s[CREDIT_W-1:0];
               state_d  = (sum_s == '0) ? ST_IDLE : ST_COLLECT;
            end
         end
         ST_LOCKOUT: begin
            credit_d = '0;
            if (coin_v_s != '0) begin
               change_vld_d = 1'b1;
               change_d     = coin_v_s[CREDIT_W-1:0];
            end else begin
               change_vld_d = 1'b0;
            end
            state_d = refill ? ST_IDLE : ST_LOCKOUT;
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = '0;
         end
      endcase
   end

   // State, credit and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         credit_q     <= '0;
         change_q     <= '0;
         out_vld_q    <= 1'b0;
         change_vld_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         change_q     <= change_d;
         out_vld_q    <= out_vld_d;
         change_vld_q <= change_vld_d;
      end
   end

   vend_stock_cnt #(
      .STOCK_INIT (STOCK_INIT),
      .STOCK_W    (STOCK_W)
   ) u_stock (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (refill),
      .dec_i   (vend_s),
      .stock_o (stock_s),
      .zero_o  (stock_zero_s)
   );

   assign out_vld    = out_vld_q;
   assign change_vld = change_vld_q;
   assign change     = change_q;
   assign credit     = credit_q;
   assign sold_out   = stock_zero_s;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench: two controller instances (PRICE 3 and 7) driven with
// identical directed and random stimulus, compared to an arithmetic model.
module tb_vend_ctrl_param;

   localparam int SINIT = 2;

   logic       clk;
   logic       rst_n;
   logic [1:0] coin;
   logic       cancel;
   logic       refill;

   logic       ov0, cv0, so0, ov1, cv1, so1;
   logic [3:0] ch0, cr0, ch1, cr1;

   int n_cmp  = 0;
   int n_fail = 0;

   int units    [4] = '{0, 1, 2, 4};
   int price    [2] = '{3, 7};
   int m_credit [2];
   int m_stock  [2];
   int e_out    [2];
   int e_cv     [2];
   int e_ch     [2];

   vend_ctrl_param #(.PRICE(3), .CREDIT_W(4), .STOCK_INIT(SINIT), .STOCK_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .refill(refill),
      .out_vld(ov0), .change_vld(cv0), .change(ch0), .credit(cr0), .sold_out(so0));

   vend_ctrl_param #(.PRICE(7), .CREDIT_W(4), .STOCK_INIT(SINIT), .STOCK_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .refill(refill),
      .out_vld(ov1), .change_vld(cv1), .change(ch1), .credit(cr1), .sold_out(so1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_credit[k] = 0;
         m_stock[k]  = SINIT;
         e_out[k] = 0; e_cv[k] = 0; e_ch[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input int c, input bit can, input bit rf);
      int v, sum, vend;
      v = units[c];
      sum = m_credit[k] + v;
      vend = 0;
      e_out[k] = 0; e_cv[k] = 0; e_ch[k] = 0;
      if (m_stock[k] == 0) begin
         if (v > 0) begin e_cv[k] = 1; e_ch[k] = v; end
         m_credit[k] = 0;
      end else if (can) begin
         if (sum > 0) begin e_cv[k] = 1; e_ch[k] = sum; end
         m_credit[k] = 0;
      end else if (sum >= price[k]) begin
         e_out[k] = 1;
         e_ch[k]  = sum - price[k];
         e_cv[k]  = (sum > price[k]) ? 1 : 0;
         m_credit[k] = 0;
         vend = 1;
      end else begin
         m_credit[k] = sum;
      end
      m_stock[k] = rf ? (SINIT - vend) : (m_stock[k] - vend);
   endtask

   task automatic check_all();
      chk("u0.out_vld",    ov0, e_out[0]);
      chk("u0.change_vld", cv0, e_cv[0]);
      chk("u0.change",     ch0, e_ch[0]);
      chk("u0.credit",     cr0, m_credit[0]);
      chk("u0.sold_out",   so0, (m_stock[0] == 0) ? 1 : 0);
      chk("u1.out_vld",    ov1, e_out[1]);
      chk("u1.change_vld", cv1, e_cv[1]);
      chk("u1.change",     ch1, e_ch[1]);
      chk("u1.credit",     cr1, m_credit[1]);
      chk("u1.sold_out",   so1, (m_stock[1] == 0) ? 1 : 0);
   endtask

   task automatic step(input int c, input bit can, input bit rf);
      coin   = 2'(c);
      cancel = can;
      refill = rf;
      model_step(0, c, can, rf);
      model_step(1, c, can, rf);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      coin = 2'd0; cancel = 1'b0; refill = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset.credit", cr0, 0);
      rst_n = 1'b1;

      // exact payment
      step(1, 0, 0); chk("exact.credit1", cr0, 1);
      step(1, 0, 0); chk("exact.credit2", cr0, 2);
      step(1, 0, 0); chk("exact.out", ov0, 1); chk("exact.cv", cv0, 0); chk("exact.credit0", cr0, 0);
      step(0, 0, 1);
      // overpay
      step(2, 0, 0);
      step(2, 0, 0); chk("over22.out", ov0, 1); chk("over22.cv", cv0, 1); chk("over22.ch", ch0, 1);
      step(1, 0, 0);
      step(3, 0, 0); chk("over13.ch", ch0, 2); chk("over13.sold", so0, 1);
      // lockout reject, refill, vend again
      step(2, 0, 0); chk("lock.cv", cv0, 1); chk("lock.ch", ch0, 2); chk("lock.out", ov0, 0);
      step(0, 0, 1); chk("refill.sold", so0, 0);
      step(1, 0, 0);
      step(2, 0, 0); chk("post_refill.out", ov0, 1);
      // refill coincident with vend leaves one unit
      step(2, 0, 0);
      step(1, 0, 1); chk("refvend.out", ov0, 1); chk("refvend.sold", so0, 0);
      step(3, 0, 0); chk("refvend.last", so0, 1);
      step(0, 0, 1);
      // cancel
      step(2, 0, 0);
      step(0, 1, 0); chk("cancel.ch", ch0, 2); chk("cancel.out", ov0, 0); chk("cancel.credit", cr0, 0);
      step(2, 0, 0);
      step(1, 1, 0); chk("cancel_coin.ch", ch0, 3);
      // reset mid-collect
      step(2, 0, 0); chk("pre_reset.credit", cr0, 2);
      coin = 2'd0; cancel = 1'b0; refill = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      rst_n = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      // stock back to 2; PRICE 7 instance: 4 then 8 -> vend, change 1
      step(3, 0, 0); chk("sweep.u1.credit", cr1, 4); chk("stk.u0.sold", so0, 0);
      step(3, 0, 0); chk("sweep.u1.out", ov1, 1); chk("sweep.u1.ch", ch1, 1); chk("stk.u0.sold2", so0, 1);
      step(0, 0, 1);

      // random phase
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0),
              ($urandom_range(15, 0) == 0));
      end
      step(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
